// File: rtl/mem_stage_rsp_if.sv
// Data-port response channel between the memory bus and the MEM stage.
// master drives data_data_ok/data_rdata, slave (the stage) consumes them.
interface mem_stage_rsp_if;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_data_ok,
    output data_rdata
  );

  modport slave (
    input data_data_ok,
    input data_rdata
  );
endinterface

// File: rtl/mem_stage_rsp.sv
// MEM stage: waits for load responses, buffers one while WS stalls,
// drops responses orphaned by flushes, aligns load data, forwards to ID.
// Ports: EX->MS handshake + fields, MS->WS handshake + result,
// forwarding bundle toward ID, data response channel (data_if), exc_flush.
module mem_stage_rsp #(
  parameter int DISCARD_W = 2,
  parameter bit LWLR_EN   = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         es_to_ms_valid,
  output logic         ms_allowin,
  input  logic [31:0]  es_pc,
  input  logic [31:0]  es_alu_result,
  input  logic [31:0]  es_rt_value,
  input  logic [5:0]   es_ls_type,
  input  logic         es_mem_re,
  input  logic         es_gpr_we,
  input  logic [4:0]   es_dest,
  input  logic         es_mtc0,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [31:0]  ms_pc,
  output logic [31:0]  ms_final_result,
  output logic         ms_gpr_we,
  output logic [4:0]   ms_dest,
  output logic         ms_fwd_valid,
  output logic [4:0]   ms_fwd_dest,
  output logic         ms_fwd_res_ok,
  output logic [31:0]  ms_fwd_result,
  mem_stage_rsp_if.slave data_if,
  input  logic         exc_flush
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [5:0]  ls;
    logic        mem_re;
    logic        gpr_we;
    logic [4:0]  dest;
    logic        mtc0;
  } ms_fld_t;

  localparam logic [DISCARD_W-1:0] CNT_MAX = '1;

  logic                 ms_valid_q, ms_valid_d;
  logic                 wait_rsp_q, wait_rsp_d;
  logic                 rbuf_v_q, rbuf_v_d;
  logic [31:0]          rbuf_q, rbuf_d;
  logic [DISCARD_W-1:0] cnt_q, cnt_d;
  ms_fld_t              fld_q, fld_d;

  logic        data_ok;
  logic        cnt_zero;
  logic        cnt_max;
  logic        rsp_own;
  logic        rsp_drop;
  logic        rsp_cur;
  logic        ms_ready_go;
  logic        ws_take;
  logic        accept;
  logic        orphan;

  assign data_ok  = data_if.data_data_ok;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_max  = (cnt_q == CNT_MAX);
  // A response belongs to us only once all orphans are drained.
  assign rsp_own  = data_ok & cnt_zero;
  assign rsp_drop = data_ok & ~cnt_zero;
  assign rsp_cur  = rsp_own & ms_valid_q
                  & wait_rsp_q & ~rbuf_v_q;

  assign ms_ready_go = ~wait_rsp_q | rbuf_v_q | rsp_own;
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go
                        & ~exc_flush;
  assign ws_take = ms_to_ws_valid & ws_allowin;
  assign ms_allowin = ~ms_valid_q
                    | (ms_ready_go & ws_allowin)
                    | exc_flush;
  assign accept = es_to_ms_valid & ms_allowin & ~exc_flush;
  // Flushed load still owed a response: its response must be dropped.
  assign orphan = exc_flush & ms_valid_q & wait_rsp_q & ~rsp_own;

  always_comb begin
    ms_valid_d = ms_valid_q;
    wait_rsp_d = wait_rsp_q;
    rbuf_v_d   = rbuf_v_q;
    rbuf_d     = rbuf_q;
    fld_d      = fld_q;
    cnt_d      = cnt_q;

    // orphan + drop together: one in, one out.
    if (orphan & ~rsp_drop & ~cnt_max)
      cnt_d = cnt_q + 1'b1;
    else if (rsp_drop & ~orphan)
      cnt_d = cnt_q - 1'b1;

    if (exc_flush) begin
      ms_valid_d = 1'b0;
      wait_rsp_d = 1'b0;
      rbuf_v_d   = 1'b0;
    end else if (accept) begin
      ms_valid_d  = 1'b1;
      wait_rsp_d  = es_mem_re;
      rbuf_v_d    = 1'b0;
      fld_d.pc     = es_pc;
      fld_d.alu    = es_alu_result;
      fld_d.rt     = es_rt_value;
      fld_d.ls     = es_ls_type;
      fld_d.mem_re = es_mem_re;
      fld_d.gpr_we = es_gpr_we;
      fld_d.dest   = es_dest;
      fld_d.mtc0   = es_mtc0;
    end else if (ws_take) begin
      ms_valid_d = 1'b0;
      wait_rsp_d = 1'b0;
      rbuf_v_d   = 1'b0;
    end else if (rsp_cur) begin
      // WS stalled: keep the response until it is taken.
      wait_rsp_d = 1'b0;
      rbuf_v_d   = 1'b1;
      rbuf_d     = data_if.data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      wait_rsp_q <= 1'b0;
      rbuf_v_q   <= 1'b0;
      rbuf_q     <= '0;
      cnt_q      <= '0;
      fld_q      <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      wait_rsp_q <= wait_rsp_d;
      rbuf_v_q   <= rbuf_v_d;
      rbuf_q     <= rbuf_d;
      cnt_q      <= cnt_d;
      fld_q      <= fld_d;
    end
  end

  a_discard_sat: assert property (
    @(posedge clk) disable iff (reset)
    !(orphan & ~rsp_drop & cnt_max));

  logic [31:0] ld;
  logic [1:0]  laddr;
  logic        uns;
  logic        is_lwl;
  logic        is_lwr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] lwl_v;
  logic [31:0] lwr_v;
  logic [31:0] aligned;
  logic [31:0] rt;

  assign ld     = rbuf_v_q ? rbuf_q : data_if.data_rdata;
  assign laddr  = fld_q.alu[1:0];
  assign uns    = fld_q.ls[5];
  assign is_lwl = LWLR_EN & fld_q.ls[3];
  assign is_lwr = LWLR_EN & fld_q.ls[4];
  assign rt     = fld_q.rt;
  assign half_v = laddr[1] ? ld[31:16] : ld[15:0];

  always_comb begin
    byte_v = ld[7:0];
    lwl_v  = ld;
    lwr_v  = ld;
    case (laddr)
      2'd0: begin
        byte_v = ld[7:0];
        lwl_v  = {ld[7:0], rt[23:0]};
        lwr_v  = ld;
      end
      2'd1: begin
        byte_v = ld[15:8];
        lwl_v  = {ld[15:0], rt[15:0]};
        lwr_v  = {rt[31:24], ld[31:8]};
      end
      2'd2: begin
        byte_v = ld[23:16];
        lwl_v  = {ld[23:0], rt[7:0]};
        lwr_v  = {rt[31:16], ld[31:16]};
      end
      default: begin
        byte_v = ld[31:24];
        lwl_v  = ld;
        lwr_v  = {rt[31:8], ld[31:24]};
      end
    endcase
  end

  always_comb begin
    aligned = ld;
    unique case (1'b1)
      is_lwr:      aligned = lwr_v;
      is_lwl:      aligned = lwl_v;
      fld_q.ls[2]: aligned = {{16{~uns & half_v[15]}}, half_v};
      fld_q.ls[1]: aligned = {{24{~uns & byte_v[7]}}, byte_v};
      default:     aligned = ld;
    endcase
  end

  always_comb begin
    ms_final_result = fld_q.alu;
    if (fld_q.mtc0)
      ms_final_result = fld_q.rt;
    else if (fld_q.mem_re)
      ms_final_result = aligned;
  end

  assign ms_pc         = fld_q.pc;
  assign ms_gpr_we     = fld_q.gpr_we;
  assign ms_dest       = fld_q.dest;
  assign ms_fwd_valid  = ms_valid_q & fld_q.gpr_we;
  assign ms_fwd_dest   = fld_q.dest;
  // Gated by ms_valid so an empty stage never claims a ready value.
  assign ms_fwd_res_ok = ms_valid_q & ms_ready_go;
  assign ms_fwd_result = ms_final_result;

endmodule

// File: tb/tb_mem_stage_rsp.sv
// Directed bench for mem_stage_rsp: loads, stalls, flush/orphan drop.
// Inputs change 1ns after posedge; outputs sampled at negedge.
module tb_mem_stage_rsp;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_alu_result;
  logic [31:0] es_rt_value;
  logic [5:0]  es_ls_type;
  logic        es_mem_re;
  logic        es_gpr_we;
  logic [4:0]  es_dest;
  logic        es_mtc0;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_final_result;
  logic        ms_gpr_we;
  logic [4:0]  ms_dest;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic        ms_fwd_res_ok;
  logic [31:0] ms_fwd_result;
  logic        exc_flush;

  int n_run = 0;
  int n_fail = 0;

  mem_stage_rsp_if bus ();

  mem_stage_rsp dut (
    .clk             (clk),
    .reset           (reset),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_pc           (es_pc),
    .es_alu_result   (es_alu_result),
    .es_rt_value     (es_rt_value),
    .es_ls_type      (es_ls_type),
    .es_mem_re       (es_mem_re),
    .es_gpr_we       (es_gpr_we),
    .es_dest         (es_dest),
    .es_mtc0         (es_mtc0),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_pc           (ms_pc),
    .ms_final_result (ms_final_result),
    .ms_gpr_we       (ms_gpr_we),
    .ms_dest         (ms_dest),
    .ms_fwd_valid    (ms_fwd_valid),
    .ms_fwd_dest     (ms_fwd_dest),
    .ms_fwd_res_ok   (ms_fwd_res_ok),
    .ms_fwd_result   (ms_fwd_result),
    .data_if         (bus),
    .exc_flush       (exc_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // A response nobody is waiting for is a protocol error.
  always @(negedge clk) begin
    if (!reset && bus.data_data_ok)
      chk("proto",
          32'(dut.cnt_q == '0 &&
              !(dut.ms_valid_q && dut.wait_rsp_q &&
                !dut.rbuf_v_q)),
          32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] alu,
                       input logic [31:0] rt,
                       input logic [5:0]  ls,
                       input logic        re,
                       input logic        mtc0);
    es_to_ms_valid = 1'b1;
    es_pc          = 32'hBFC0_0000 + alu;
    es_alu_result  = alu;
    es_rt_value    = rt;
    es_ls_type     = ls;
    es_mem_re      = re;
    es_gpr_we      = 1'b1;
    es_dest        = 5'd7;
    es_mtc0        = mtc0;
    step();
    es_to_ms_valid = 1'b0;
  endtask

  // Load answered in its first MS cycle; returns the result.
  task automatic load1(input string tag,
                       input logic [31:0] alu,
                       input logic [31:0] rt,
                       input logic [5:0]  ls,
                       input logic [31:0] rd,
                       input logic [31:0] exp);
    issue(alu, rt, ls, 1'b1, 1'b0);
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = rd;
    smp();
    chk({tag, "_v"}, 32'(ms_to_ws_valid), 32'd1);
    chk({tag, "_r"}, ms_final_result, exp);
    step();
    bus.data_data_ok = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    es_to_ms_valid   = 1'b0;
    es_pc            = '0;
    es_alu_result    = '0;
    es_rt_value      = '0;
    es_ls_type       = '0;
    es_mem_re        = 1'b0;
    es_gpr_we        = 1'b0;
    es_dest          = '0;
    es_mtc0          = 1'b0;
    ws_allowin       = 1'b1;
    exc_flush        = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = '0;
    step();
    step();
    reset = 1'b0;
    smp();
    chk("rst_v", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_fv", 32'(ms_fwd_valid), 32'd0);
    chk("rst_ok", 32'(ms_fwd_res_ok), 32'd0);
    chk("rst_ai", 32'(ms_allowin), 32'd1);
    step();

    // ADD: pass-through of alu_result
    issue(32'h1234, 32'h0, 6'b0, 1'b0, 1'b0);
    smp();
    chk("add_v", 32'(ms_to_ws_valid), 32'd1);
    chk("add_r", ms_final_result, 32'h0000_1234);
    chk("add_fv", 32'(ms_fwd_valid), 32'd1);
    chk("add_fd", 32'(ms_fwd_dest), 32'd7);
    chk("add_ok", 32'(ms_fwd_res_ok), 32'd1);
    step();
    smp();
    chk("add_gone", 32'(ms_to_ws_valid), 32'd0);
    step();

    // LB laddr=3, response on the third MS cycle
    issue(32'h1003, 32'h0, 6'b000010, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("lb_wait_v", 32'(ms_to_ws_valid), 32'd0);
      chk("lb_wait_ok", 32'(ms_fwd_res_ok), 32'd0);
      chk("lb_wait_ai", 32'(ms_allowin), 32'd0);
      step();
    end
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h80FF_0000;
    smp();
    chk("lb_v", 32'(ms_to_ws_valid), 32'd1);
    chk("lb_r", ms_final_result, 32'hFFFF_FF80);
    chk("lb_ok", 32'(ms_fwd_res_ok), 32'd1);
    step();
    bus.data_data_ok = 1'b0;
    smp();
    chk("lb_gone", 32'(ms_to_ws_valid), 32'd0);
    step();

    // LHU laddr=2 with WS stalled at data_ok
    issue(32'h2002, 32'h0, 6'b100100, 1'b1, 1'b0);
    ws_allowin       = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hBEEF_0001;
    smp();
    chk("lhu_r0", ms_final_result, 32'h0000_BEEF);
    step();
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h1234_5678;
    smp();
    chk("lhu_hold_v", 32'(ms_to_ws_valid), 32'd1);
    chk("lhu_hold_r", ms_final_result, 32'h0000_BEEF);
    step();
    ws_allowin = 1'b1;
    smp();
    chk("lhu_v", 32'(ms_to_ws_valid), 32'd1);
    chk("lhu_r", ms_final_result, 32'h0000_BEEF);
    step();
    smp();
    chk("lhu_gone", 32'(ms_to_ws_valid), 32'd0);
    step();

    // Aligner table
    load1("lwl1", 32'h0001, 32'h1122_3344, 6'b001000,
          32'hAABB_CCDD, 32'hCCDD_3344);
    load1("lwl3", 32'h0003, 32'h1122_3344, 6'b001000,
          32'hAABB_CCDD, 32'hAABB_CCDD);
    load1("lwr2", 32'h0002, 32'h1122_3344, 6'b010000,
          32'hAABB_CCDD, 32'h1122_AABB);
    load1("lwr3", 32'h0003, 32'h1122_3344, 6'b010000,
          32'hAABB_CCDD, 32'h1122_33AA);
    load1("lh0", 32'h0000, 32'h0, 6'b000100,
          32'h1234_8001, 32'hFFFF_8001);
    load1("lbu1", 32'h0001, 32'h0, 6'b100010,
          32'h0000_9A00, 32'h0000_009A);
    load1("lw", 32'h0010, 32'h0, 6'b000001,
          32'hCAFE_F00D, 32'hCAFE_F00D);

    // MTC0 takes rt_value
    issue(32'h0, 32'hCAFE_BABE, 6'b0, 1'b0, 1'b1);
    smp();
    chk("mtc0_r", ms_final_result, 32'hCAFE_BABE);
    step();

    // Flush while waiting, then orphan dropped
    issue(32'h3000, 32'h0, 6'b000001, 1'b1, 1'b0);
    exc_flush = 1'b1;
    smp();
    chk("fl_v", 32'(ms_to_ws_valid), 32'd0);
    chk("fl_ai", 32'(ms_allowin), 32'd1);
    step();
    exc_flush = 1'b0;
    smp();
    chk("fl_cnt", 32'(dut.cnt_q), 32'd1);
    chk("fl_gone", 32'(ms_to_ws_valid), 32'd0);
    step();
    issue(32'h3004, 32'h0, 6'b000001, 1'b1, 1'b0);
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h0000_DEAD;
    smp();
    chk("orph_v", 32'(ms_to_ws_valid), 32'd0);
    step();
    bus.data_rdata = 32'h5A5A_5A5A;
    smp();
    chk("orph_cnt", 32'(dut.cnt_q), 32'd0);
    chk("orph_nv", 32'(ms_to_ws_valid), 32'd1);
    chk("orph_r", ms_final_result, 32'h5A5A_5A5A);
    step();
    bus.data_data_ok = 1'b0;

    // Flush in the same cycle as data_ok
    issue(32'h4000, 32'h0, 6'b000001, 1'b1, 1'b0);
    exc_flush        = 1'b1;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h7777_7777;
    smp();
    chk("fls_v", 32'(ms_to_ws_valid), 32'd0);
    step();
    exc_flush        = 1'b0;
    bus.data_data_ok = 1'b0;
    smp();
    chk("fls_cnt", 32'(dut.cnt_q), 32'd0);
    chk("fls_gone", 32'(ms_to_ws_valid), 32'd0);
    step();

    // Reset mid-wait clears discard counter too
    issue(32'h5000, 32'h0, 6'b000001, 1'b1, 1'b0);
    exc_flush = 1'b1;
    step();
    exc_flush = 1'b0;
    issue(32'h5004, 32'h0, 6'b000001, 1'b1, 1'b0);
    smp();
    chk("rmw_cnt1", 32'(dut.cnt_q), 32'd1);
    chk("rmw_wait", 32'(ms_to_ws_valid), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    smp();
    chk("rmw_cnt", 32'(dut.cnt_q), 32'd0);
    chk("rmw_v", 32'(ms_to_ws_valid), 32'd0);
    chk("rmw_ok", 32'(ms_fwd_res_ok), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
